// File: rtl/serial_shift_unit_pkg.sv
// Shared types for the serial shifter: FSM states, shift modes and default widths.
// Build macro SERIAL_SHIFT_ROTATE_EN enables the rotate modes at the interface.
package serial_shift_unit_pkg;

  localparam int unsigned DefWidth   = 16;
  localparam int unsigned DefAmtBits = 4;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StFinish
  } state_e;

  typedef enum logic [2:0] {
    ShLeft,
    ShRightLog,
    ShRightArith,
    ShRotLeft,
    ShRotRight
  } shift_mode_e;

  // Rotate overrides Arith; Arith only matters for right shifts.
  function automatic shift_mode_e mode_sel(input logic left, input logic arith,
                                           input logic rotate);
    shift_mode_e mode;
    if (rotate) begin
      mode = left ? ShRotLeft : ShRotRight;
    end else if (left) begin
      mode = ShLeft;
    end else begin
      mode = arith ? ShRightArith : ShRightLog;
    end
    return mode;
  endfunction

endpackage

// File: rtl/serial_shift_unit_if.sv
// Start/Done handshake bundle for the serial shifter.
// Build macro SERIAL_SHIFT_ROTATE_EN adds the rotate request bit.
interface serial_shift_unit_if
  import serial_shift_unit_pkg::*;
#(
  parameter int unsigned Width   = DefWidth,
  parameter int unsigned AmtBits = DefAmtBits
);

  logic               start;
  logic [Width-1:0]   din;
  logic [AmtBits-1:0] amount;
  logic               left;
  logic               arith;
`ifdef SERIAL_SHIFT_ROTATE_EN
  logic               rotate;
`endif
  logic               busy;
  logic               done;
  logic [Width-1:0]   dout;

  modport master (
    output start, din, amount, left, arith,
`ifdef SERIAL_SHIFT_ROTATE_EN
    output rotate,
`endif
    input  busy, done, dout
  );

  modport slave (
    input  start, din, amount, left, arith,
`ifdef SERIAL_SHIFT_ROTATE_EN
    input  rotate,
`endif
    output busy, done, dout
  );

endinterface

// File: rtl/serial_shift_unit_shift_step.sv
// Combinational single-bit shift/rotate step applied once per SHIFT cycle.
module serial_shift_unit_shift_step
  import serial_shift_unit_pkg::*;
#(
  parameter int unsigned Width = DefWidth
) (
  input  shift_mode_e      mode_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    unique case (mode_i)
      ShLeft:       data_o = {data_i[Width-2:0], 1'b0};
      ShRightLog:   data_o = {1'b0, data_i[Width-1:1]};
      ShRightArith: data_o = {data_i[Width-1], data_i[Width-1:1]};
      ShRotLeft:    data_o = {data_i[Width-2:0], data_i[Width-1]};
      ShRotRight:   data_o = {data_i[0], data_i[Width-1:1]};
      default:      data_o = data_i;
    endcase
  end

endmodule

// File: rtl/serial_shift_unit.sv
// Multi-cycle shifter, one bit per clock, for register-held amounts; Start/Done handshake.
// Build macro SERIAL_SHIFT_ROTATE_EN enables rotate requests through the interface.
module serial_shift_unit
  import serial_shift_unit_pkg::*;
#(
  parameter int unsigned Width   = DefWidth,
  parameter int unsigned AmtBits = DefAmtBits
) (
  input logic                clk_i,
  input logic                rst_ni,
  serial_shift_unit_if.slave bus_io
);

  state_e             state_q;
  shift_mode_e        mode_q;
  logic [AmtBits-1:0] count_q;
  logic [Width-1:0]   dout_q;
  logic [Width-1:0]   step_d;
  logic               busy_q;
  logic               done_q;
  logic               rotate_in;

`ifdef SERIAL_SHIFT_ROTATE_EN
  assign rotate_in = bus_io.rotate;
`else
  assign rotate_in = 1'b0;
`endif

  serial_shift_unit_shift_step #(
    .Width (Width)
  ) u_shift_step (
    .mode_i (mode_q),
    .data_i (dout_q),
    .data_o (step_d)
  );

  // Done is registered on leaving StFinish, so a new Start is also held off while done_q is up.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      mode_q  <= ShLeft;
      count_q <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus_io.start && !done_q) begin
            dout_q  <= bus_io.din;
            count_q <= bus_io.amount;
            mode_q  <= mode_sel(bus_io.left, bus_io.arith, rotate_in);
            if (bus_io.amount != '0) begin
              state_q <= StShift;
              busy_q  <= 1'b1;
            end else begin
              state_q <= StFinish;
            end
          end
        end
        StShift: begin
          dout_q  <= step_d;
          count_q <= count_q - AmtBits'(1);
          if (count_q == AmtBits'(1)) begin
            state_q <= StFinish;
            busy_q  <= 1'b0;
          end
        end
        StFinish: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.busy = busy_q;
  assign bus_io.done = done_q;
  assign bus_io.dout = dout_q;

endmodule

// File: tb/tb_serial_shift_unit.sv
// Scoreboard bench for serial_shift_unit: directed corner cases plus random shifts.
module tb_serial_shift_unit;
  import serial_shift_unit_pkg::*;

  typedef struct {
    logic [15:0] dout;
    int          done_cyc;
    int          busy_cyc;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_shift_unit_if bus ();

  serial_shift_unit dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference computed directly from the shift definitions, all bits at once.
  function automatic logic [15:0] model(input logic [15:0] d, input int amt, input bit left,
                                        input bit arith, input bit rot);
    logic [31:0] dd;
    dd = {d, d};
    if (rot) begin
      if (left) begin
        dd = dd << amt;
        return dd[31:16];
      end
      dd = dd >> amt;
      return dd[15:0];
    end
    if (left) return d << amt;
    if (arith) return 16'($signed(d) >>> amt);
    return d >> amt;
  endfunction

  // Monitor: pops the scoreboard on every Done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_dout"}, bus.dout, e.dout);
          check({e.name, "_latency"}, cyc, e.done_cyc);
          check({e.name, "_busy_cycles"}, busy_cnt, e.busy_cyc);
          check({e.name, "_busy_at_done"}, bus.busy, 0);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input string name, input logic [15:0] din, input int amt, input bit left,
                       input bit arith, input bit rot, input bit push);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.din    = din;
    bus.amount = 4'(amt);
    bus.left   = left;
    bus.arith  = arith;
`ifdef SERIAL_SHIFT_ROTATE_EN
    bus.rotate = rot;
`endif
    @(posedge clk);
    #1;
    if (push) exp_q.push_back('{model(din, amt, left, arith, rot), cyc + amt + 1, amt, name});
    @(negedge clk);
    // Scramble operands so a late capture would corrupt the result.
    bus.start  = 1'b0;
    bus.din    = 16'($urandom);
    bus.amount = 4'($urandom);
    bus.left   = 1'($urandom);
    bus.arith  = 1'($urandom);
  endtask

  task automatic wait_done(input string name, input logic [15:0] req);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done within 100 cycles, required done", name);
      exp_q.delete();
    end
    @(negedge clk);
    check({name, "_dout_hold"}, bus.dout, req);
  endtask

  task automatic run(input string name, input logic [15:0] din, input int amt, input bit left,
                     input bit arith, input bit rot);
    issue(name, din, amt, left, arith, rot, 1'b1);
    wait_done(name, model(din, amt, left, arith, rot));
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.din    = '0;
    bus.amount = '0;
    bus.left   = 1'b0;
    bus.arith  = 1'b0;
`ifdef SERIAL_SHIFT_ROTATE_EN
    bus.rotate = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_dout", bus.dout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run("arith_r1", 16'h8101, 1, 1'b0, 1'b1, 1'b0);
    run("left_1", 16'h1111, 1, 1'b1, 1'b0, 1'b0);
    run("left_4", 16'h0F0F, 4, 1'b1, 1'b0, 1'b0);
    run("log_r15", 16'h8000, 15, 1'b0, 1'b0, 1'b0);
    run("arith_r15", 16'h8000, 15, 1'b0, 1'b1, 1'b0);
    run("amt0", 16'h1234, 0, 1'b0, 1'b0, 1'b0);
    run("left_arith_ign", 16'h8001, 3, 1'b1, 1'b1, 1'b0);

    // Start pulsed mid-shift must be ignored.
    issue("midstart", 16'h00F3, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    bus.start  = 1'b1;
    bus.din    = 16'hFFFF;
    bus.amount = 4'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("midstart", model(16'h00F3, 8, 1'b0, 1'b0, 1'b0));

    // Reset mid-shift aborts the operation.
    issue("abort", 16'hABCD, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_dout", bus.dout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    busy_cnt = 0;
    run("after_abort", 16'h5A5A, 2, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_SHIFT_ROTATE_EN
    run("rot_r1", 16'h8001, 1, 1'b0, 1'b1, 1'b1);
    run("rot_l1", 16'h8001, 1, 1'b1, 1'b0, 1'b1);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [15:0] d;
      int          a;
      bit          l, ar, ro;
      d  = 16'($urandom);
      a  = int'($urandom_range(0, 15));
      l  = 1'($urandom);
      ar = 1'($urandom);
      ro = 1'b0;
`ifdef SERIAL_SHIFT_ROTATE_EN
      ro = 1'($urandom);
`endif
      run("rand", d, a, l, ar, ro);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
